// File: rtl/key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_ctrl
// Description : Debounces one raw push-button and turns it into clean control
//               events: a debounced level, single-cycle press / release /
//               long-press / auto-repeat strobes, and a toggle level that
//               flips on every accepted press (drives the LED direction).
// Ports       :
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   key_in         in   raw button pin (asynchronous, bouncy)
//   key_level      out  debounced state, 1 = pressed
//   press_pulse    out  1-cycle strobe when a press is accepted
//   release_pulse  out  1-cycle strobe when a release is accepted
//   long_pulse     out  1-cycle strobe, once per hold, LONG_CYC after press
//   repeat_pulse   out  1-cycle strobe every REPEAT_CYC after long_pulse
//   toggle         out  level inverted together with press_pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ctrl #(
   parameter int unsigned DEBOUNCE_CYC   = 2_000_000,
   parameter int unsigned LONG_CYC       = 100_000_000,
   parameter int unsigned REPEAT_CYC     = 20_000_000,
   parameter bit          KEY_ACTIVE_LOW = 1'b1,
   parameter bit          TOGGLE_INIT    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic toggle
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_W = $clog2(LONG_CYC + 1);
   localparam int REP_W  = $clog2(REPEAT_CYC + 1);

   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYC);
   localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYC - 1);
   localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

   // Raw pin level of a released key; the synchronizer resets to it so a key
   // held through reset is seen as a fresh press afterwards.
   localparam logic KEY_RELEASED = KEY_ACTIVE_LOW;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_PRESS_DB   = 2'd1,
      S_HELD       = 2'd2,
      S_RELEASE_DB = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Input synchronizer and polarity normalization
   // -------------------------------------------------------------------------
   logic sync1;
   logic sync2;
   logic pressed;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= KEY_RELEASED;
         sync2 <= KEY_RELEASED;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   assign pressed = sync2 ^ KEY_ACTIVE_LOW;

   // -------------------------------------------------------------------------
   // State and counter registers
   // -------------------------------------------------------------------------
   state_t              state,    state_nx;
   logic [DB_W-1:0]     db_cnt,   db_nx;
   logic [HOLD_W-1:0]   hold_cnt, hold_nx;
   logic [REP_W-1:0]    rep_cnt,  rep_nx;
   logic                level_nx, press_nx, release_nx, long_nx, repeat_nx;
   logic                toggle_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         toggle        <= TOGGLE_INIT;
      end else begin
         state         <= state_nx;
         db_cnt        <= db_nx;
         hold_cnt      <= hold_nx;
         rep_cnt       <= rep_nx;
         key_level     <= level_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         long_pulse    <= long_nx;
         repeat_pulse  <= repeat_nx;
         toggle        <= toggle_nx;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and registered-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      db_nx      = db_cnt;
      hold_nx    = hold_cnt;
      rep_nx     = rep_cnt;
      level_nx   = key_level;
      toggle_nx  = toggle;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;

      case (state)
         S_IDLE: begin
            if (pressed) begin
               state_nx = S_PRESS_DB;
               db_nx    = DB_ONE;
            end
         end

         S_PRESS_DB: begin
            // Any released sample throws away the whole run: no partial credit.
            if (!pressed) begin
               state_nx = S_IDLE;
               db_nx    = '0;
            end else if (db_cnt == DB_MAX) begin
               state_nx  = S_HELD;
               db_nx     = '0;
               hold_nx   = '0;
               rep_nx    = '0;
               press_nx  = 1'b1;
               level_nx  = 1'b1;
               toggle_nx = ~toggle;
            end else begin
               db_nx = db_cnt + DB_ONE;
            end
         end

         S_HELD: begin
            // Hold timing advances on every HELD cycle, including the one that
            // leaves for RELEASE_DB. Once hold_cnt saturates, rep_cnt runs.
            if (hold_cnt != HOLD_MAX) begin
               hold_nx = hold_cnt + HOLD_ONE;
               long_nx = (hold_cnt == HOLD_PRE);
            end else if (rep_cnt == REP_LAST) begin
               rep_nx    = '0;
               repeat_nx = 1'b1;
            end else begin
               rep_nx = rep_cnt + REP_ONE;
            end
            if (!pressed) begin
               state_nx = S_RELEASE_DB;
               db_nx    = DB_ONE;
            end
         end

         S_RELEASE_DB: begin
            // hold_cnt / rep_cnt stay frozen so a glitch only delays timing.
            if (pressed) begin
               state_nx = S_HELD;
               db_nx    = '0;
            end else if (db_cnt == DB_MAX) begin
               state_nx   = S_IDLE;
               db_nx      = '0;
               hold_nx    = '0;
               rep_nx     = '0;
               release_nx = 1'b1;
               level_nx   = 1'b0;
            end else begin
               db_nx = db_cnt + DB_ONE;
            end
         end

         default: begin
            state_nx = S_IDLE;
            db_nx    = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_ctrl
// Description : Self-checking bench for key_debounce_ctrl. Two instances share
//               one stimulus: an active-low one and an active-high one fed the
//               inverted pin, so both must match the same reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_ctrl;

   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int REP  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key = 1'b1;            // active-low pin: 1 = released
   logic key_h;

   assign key_h = ~key;

   logic level_l, press_l, rel_l, long_l, rep_l, tog_l;
   logic level_h, press_h, rel_h, long_h, rep_h, tog_h;

   key_debounce_ctrl #(
      .DEBOUNCE_CYC(DB), .LONG_CYC(LONG), .REPEAT_CYC(REP),
      .KEY_ACTIVE_LOW(1'b1), .TOGGLE_INIT(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key),
      .key_level(level_l), .press_pulse(press_l), .release_pulse(rel_l),
      .long_pulse(long_l), .repeat_pulse(rep_l), .toggle(tog_l)
   );

   key_debounce_ctrl #(
      .DEBOUNCE_CYC(DB), .LONG_CYC(LONG), .REPEAT_CYC(REP),
      .KEY_ACTIVE_LOW(1'b0), .TOGGLE_INIT(1'b1)
   ) dut_h (
      .clk(clk), .rst(rst), .key_in(key_h),
      .key_level(level_h), .press_pulse(press_h), .release_pulse(rel_h),
      .long_pulse(long_h), .repeat_pulse(rep_h), .toggle(tog_h)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // -------------------------------------------------------------------------
   // Reference model: a key level is accepted after DB+1 consecutive opposite
   // samples, samples reach the decision 2 cycles late. "held" counts cycles
   // spent settled in the pressed state; long/repeat follow arithmetically.
   // -------------------------------------------------------------------------
   bit m_hist1, m_hist2;
   bit m_level, m_toggle;
   bit e_press, e_rel, e_long, e_rep;
   int streak, held;

   always @(posedge clk) begin : model
      bit p;
      if (rst) begin
         m_hist1 = 1'b0; m_hist2 = 1'b0;
         m_level = 1'b0; m_toggle = 1'b1;
         e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
         streak = 0; held = 0;
      end else begin
         p = m_hist2;
         e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
         if (m_level && streak == 0) begin
            held++;
            if (held == LONG) e_long = 1'b1;
            else if (held > LONG && (held - LONG) % REP == 0) e_rep = 1'b1;
         end
         if (p != m_level) begin
            streak++;
            if (streak == DB + 1) begin
               m_level = p;
               streak  = 0;
               held    = 0;
               if (p) begin
                  e_press  = 1'b1;
                  m_toggle = ~m_toggle;
               end else begin
                  e_rel = 1'b1;
               end
            end
         end else begin
            streak = 0;
         end
         m_hist2 = m_hist1;
         m_hist1 = (key == 1'b0);
      end
   end

   wire [5:0] obs_l = {level_l, press_l, rel_l, long_l, rep_l, tog_l};
   wire [5:0] obs_h = {level_h, press_h, rel_h, long_h, rep_h, tog_h};
   wire [5:0] exp_v = {m_level, e_press, e_rel, e_long, e_rep, m_toggle};

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      key = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (obs_l !== 6'b000001 || obs_h !== 6'b000001) begin
         failed++;
         $display("FAIL reset: low=%b high=%b expected=000001", obs_l, obs_h);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_press();
      int pc = 0, rc = 0, pa = -1, ra = -1;
      for (int i = 0; i < 26; i++) begin
         key = (i < 12) ? 1'b0 : 1'b1;
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL clean_press cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
         if (press_l) begin pc++; pa = i; end
         if (rel_l)   begin rc++; ra = i; end
         if (i == 8) begin
            tests++;
            if (tog_l !== 1'b0 || level_l !== 1'b1) begin
               failed++;
               $display("FAIL clean_press_level: toggle=%b level=%b expected toggle=0 level=1", tog_l, level_l);
            end
         end
      end
      tests++;
      if (pc != 1 || pa != 6) begin
         failed++;
         $display("FAIL clean_press_timing: count=%0d at=%0d expected count=1 at=6", pc, pa);
      end
      tests++;
      if (rc != 1 || ra != 18) begin
         failed++;
         $display("FAIL clean_release_timing: count=%0d at=%0d expected count=1 at=18", rc, ra);
      end
   endtask

   task automatic test_bounce();
      int pc = 0, pa = -1;
      for (int i = 0; i < 44; i++) begin
         if (i < 12)      key = (i % 4 == 3) ? 1'b1 : 1'b0;
         else if (i < 31) key = 1'b0;
         else             key = 1'b1;
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL bounce cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
         if (press_l) begin pc++; pa = i; end
      end
      tests++;
      if (pc != 1 || pa != 18) begin
         failed++;
         $display("FAIL bounce_press: count=%0d at=%0d expected count=1 at=18", pc, pa);
      end
   endtask

   task automatic test_long_hold();
      int lc = 0, la = -1, rpc = 0, rp_first = -1, rp_last = -1, rc = 0, ra = -1;
      for (int i = 0; i < 60; i++) begin
         key = (i < 42) ? 1'b0 : 1'b1;
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL long_hold cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
         if (long_l) begin lc++; la = i; end
         if (rep_l) begin
            rpc++;
            if (rp_first < 0) rp_first = i;
            rp_last = i;
         end
         if (rel_l) begin rc++; ra = i; end
      end
      tests++;
      if (lc != 1 || la != 26) begin
         failed++;
         $display("FAIL long_pulse: count=%0d at=%0d expected count=1 at=26", lc, la);
      end
      tests++;
      if (rpc != 3 || rp_first != 31 || rp_last != 41) begin
         failed++;
         $display("FAIL repeat_pulse: count=%0d first=%0d last=%0d expected 3 from 31 to 41", rpc, rp_first, rp_last);
      end
      tests++;
      if (rc != 1 || ra != 48) begin
         failed++;
         $display("FAIL long_release: count=%0d at=%0d expected count=1 at=48", rc, ra);
      end
   endtask

   task automatic test_glitch();
      int pc = 0, lc = 0, la = -1, rc = 0, ra = -1;
      for (int i = 0; i < 56; i++) begin
         if (i < 40) key = (i == 16 || i == 17) ? 1'b1 : 1'b0;
         else        key = 1'b1;
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL glitch cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
         if (press_l) pc++;
         if (long_l) begin lc++; la = i; end
         if (rel_l)  begin rc++; ra = i; end
      end
      tests++;
      if (pc != 1 || rc != 1 || ra != 46) begin
         failed++;
         $display("FAIL glitch_events: presses=%0d releases=%0d rel_at=%0d expected 1/1/46", pc, rc, ra);
      end
      tests++;
      if (lc != 1 || la != 28) begin
         failed++;
         $display("FAIL glitch_long: count=%0d at=%0d expected count=1 at=28", lc, la);
      end
   endtask

   task automatic test_reset_in_held();
      int pc = 0, pa = -1;
      for (int i = 0; i < 46; i++) begin
         rst = (i == 12);
         key = (i < 30) ? 1'b0 : 1'b1;
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL reset_held cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
         if (i == 12) begin
            tests++;
            if (obs_l !== 6'b000001 || obs_h !== 6'b000001) begin
               failed++;
               $display("FAIL reset_held_outputs: low=%b high=%b expected=000001", obs_l, obs_h);
            end
         end
         if (press_l) begin pc++; pa = i; end
      end
      rst = 1'b0;
      tests++;
      if (pc != 2 || pa != 19) begin
         failed++;
         $display("FAIL reset_held_repress: count=%0d last_at=%0d expected count=2 last_at=19", pc, pa);
      end
   endtask

   task automatic test_active_high();
      int pc = 0;
      rst = 1'b1;
      key = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 96; i++) begin
         key = ((i % 24) < 12) ? 1'b0 : 1'b1;
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL active_high cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
         if (press_h) pc++;
      end
      tests++;
      if (pc != 4 || tog_h !== 1'b1) begin
         failed++;
         $display("FAIL active_high_toggle: presses=%0d toggle=%b expected presses=4 toggle=1", pc, tog_h);
      end
   endtask

   task automatic test_random();
      int remaining = 0;
      int sel;
      for (int i = 0; i < 3000; i++) begin
         if (remaining == 0) begin
            key = ~key;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      remaining = int'($urandom_range(1, 6));
            else if (sel < 8) remaining = int'($urandom_range(5, 12));
            else              remaining = int'($urandom_range(20, 60));
         end
         remaining--;
         rst = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         tests++;
         if (obs_l !== exp_v || obs_h !== exp_v) begin
            failed++;
            $display("FAIL random cyc %0d: low=%b high=%b expected=%b", i, obs_l, obs_h, exp_v);
         end
      end
      rst = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   initial begin
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_hold();
      test_glitch();
      test_reset_in_held();
      test_active_high();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
